ir: RTL and testbench

- Instruction register of the 16-bit mycpu core; sits between instruction memory/bus and the control unit/datapath.
- Captures the fetched instruction word when the load strobe from control is asserted.
- Presents three decoded views continuously:
  - the raw instruction, to the decoder
  - a zero-extended address field, to the PC/address mux
  - a sign-extended immediate value, to the ALU operand mux

---
 rtl/mycpu_pkg.sv | 14 +
 rtl/ir_sva.sv | 47 ++++
 rtl/ir.sv | 37 +++
 tb/tb_ir.sv | 123 ++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared constants for the 16-bit mycpu core.
// Used by the instruction register, the decoder and the testbenches.
package mycpu_pkg;

  localparam int CLK_PERIOD = 10;
  localparam int DATA_WIDTH = 16;
  localparam int IA_WIDTH   = 12;
  localparam int IV_WIDTH   = 8;

  // Opcode occupies the top nibble of every instruction word.
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

endpackage

// File: rtl/ir_sva.sv
// Protocol and field-consistency checks for the instruction register.
// Attached to every ir instance through the bind below.
module ir_sva
  import mycpu_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int AW = IA_WIDTH,
  parameter int VW = IV_WIDTH
) (
  input logic          clk,
  input logic          rst_n,
  input logic          il_in,
  input logic [DW-1:0] ins_in,
  input logic [DW-1:0] ins_out,
  input logic [DW-1:0] ia_out,
  input logic [DW-1:0] iv_out
);

  a_reset_clear : assert property (@(posedge clk) !rst_n |-> ins_out == {DW{1'b0}})
    else $error("ir_sva: register not clear during reset");

  a_il_known : assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(il_in))
    else $error("ir_sva: il_in unknown");

  a_hold : assert property (@(posedge clk) disable iff (!rst_n) !il_in |=> $stable(ins_out))
    else $error("ir_sva: ins_out changed without load");

  a_load : assert property (@(posedge clk) disable iff (!rst_n) il_in |=> ins_out == $past(ins_in))
    else $error("ir_sva: loaded word differs from sampled ins_in");

  a_ia_upper : assert property (@(posedge clk) ia_out[DW-1:AW] == {(DW-AW){1'b0}})
    else $error("ir_sva: ia_out upper bits not zero");

  a_iv_sign : assert property (@(posedge clk) iv_out[DW-1:VW] == {(DW-VW){iv_out[VW-1]}})
    else $error("ir_sva: iv_out upper bits not a sign extension");

endmodule

bind ir ir_sva #(.DW(DW), .AW(AW), .VW(VW)) u_ir_sva (
  .clk     (clk),
  .rst_n   (rst_n),
  .il_in   (il_in),
  .ins_in  (ins_in),
  .ins_out (ins_out),
  .ia_out  (ia_out),
  .iv_out  (iv_out)
);

// File: rtl/ir.sv
// Instruction register: captures the fetched word on il_in and presents
// raw, zero-extended address and sign-extended immediate views of it.
module ir
  import mycpu_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int AW = IA_WIDTH,
  parameter int VW = IV_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          il_in,
  input  logic [DW-1:0] ins_in,
  output logic [DW-1:0] ins_out,
  output logic [DW-1:0] ia_out,
  output logic [DW-1:0] iv_out
);

  logic [DW-1:0] ir_r;

  // Capture the instruction word on a load strobe; hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_r <= {DW{1'b0}};
    end else if (il_in) begin
      ir_r <= ins_in;
    end else begin
      ir_r <= ir_r;
    end
  end

  // Outputs depend only on the held register, never on ins_in or il_in.
  assign ins_out = ir_r;
  assign ia_out  = {{(DW-AW){1'b0}}, ir_r[AW-1:0]};
  assign iv_out  = {{(DW-VW){ir_r[VW-1]}}, ir_r[VW-1:0]};

endmodule

// File: tb/tb_ir.sv
// Directed self-checking bench for the instruction register.
module tb_ir;
  import mycpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        il_in;
  logic [15:0] ins_in;
  logic [15:0] ins_out;
  logic [15:0] ia_out;
  logic [15:0] iv_out;

  int checks = 0;
  int errors = 0;

  ir #(.DW(16), .AW(12), .VW(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .il_in   (il_in),
    .ins_in  (ins_in),
    .ins_out (ins_out),
    .ia_out  (ia_out),
    .iv_out  (iv_out)
  );

  initial clk = 1'b0;
  always #(CLK_PERIOD/2) clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [15:0] e_ins,
                      input logic [15:0] e_ia, input logic [15:0] e_iv);
    chk({tag, ".ins"}, ins_out, e_ins);
    chk({tag, ".ia"},  ia_out,  e_ia);
    chk({tag, ".iv"},  iv_out,  e_iv);
  endtask

  // Drive a word at the falling edge, then sample just after the rising edge.
  task automatic cycle(input logic il, input logic [15:0] w);
    @(negedge clk);
    il_in  = il;
    ins_in = w;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    il_in  = 1'b1;
    ins_in = 16'hFFFF;
    #1;
    chk3("reset_t0", 16'h0000, 16'h0000, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk3("reset_held", 16'h0000, 16'h0000, 16'h0000);
    end

    @(negedge clk);
    rst_n = 1'b1;
    il_in = 1'b0;

    cycle(1'b1, 16'h1A7F);
    chk3("pos_imm", 16'h1A7F, 16'h0A7F, 16'h007F);

    cycle(1'b1, 16'hC380);
    chk3("neg_imm", 16'hC380, 16'h0380, 16'hFF80);

    cycle(1'b1, 16'h1234);
    chk3("load_1234", 16'h1234, 16'h0234, 16'h0034);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 16'hBEEF);
      chk("hold.ins", ins_out, 16'h1234);
    end
    chk("hold.ia", ia_out, 16'h0234);
    chk("hold.iv", iv_out, 16'h0034);

    cycle(1'b1, 16'h0001);
    chk("b2b0.iv", iv_out, 16'h0001);
    chk("b2b0.ia", ia_out, 16'h0001);
    cycle(1'b1, 16'h00FF);
    chk("b2b1.iv", iv_out, 16'hFFFF);
    chk("b2b1.ia", ia_out, 16'h00FF);
    cycle(1'b1, 16'hF000);
    chk("b2b2.iv", iv_out, 16'h0000);
    chk("b2b2.ia", ia_out, 16'h0000);
    chk("b2b2.ins", ins_out, 16'hF000);

    cycle(1'b1, 16'h5555);
    chk3("pre_async", 16'h5555, 16'h0555, 16'h0055);
    @(negedge clk);
    il_in  = 1'b1;
    ins_in = 16'hFFFF;
    #2;
    rst_n = 1'b0;
    #1;
    chk3("async_rst", 16'h0000, 16'h0000, 16'h0000);
    @(posedge clk);
    #1;
    chk3("async_rst_edge", 16'h0000, 16'h0000, 16'h0000);

    @(negedge clk);
    rst_n  = 1'b1;
    il_in  = 1'b1;
    ins_in = 16'h00AA;
    @(posedge clk);
    #1;
    chk3("post_rst_load", 16'h00AA, 16'h00AA, 16'hFFAA);

    cycle(1'b0, 16'h7FFF);
    chk3("post_rst_hold", 16'h00AA, 16'h00AA, 16'hFFAA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
